// File: rtl/param_cpu.sv
// Parametrised 16-register CPU: 1 cycle per instruction, memory ops hold in WAIT until mem_ack.
// Backpressure: a slow data memory stalls the core by withholding mem_ack; HALT exits only via reset.
module param_cpu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int PC_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   inst_addr,
    input  logic [15:0]       inst_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;
    typedef enum logic [3:0] {
        OP_NOP, OP_LOAD, OP_STORE, OP_SET, OP_LT, OP_EQ, OP_BEQ, OP_BNEQ,
        OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_INV, OP_XOR
    } op_t;
    localparam logic [15:0] HALT_INST = 16'h0FFF;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt;
    logic [DATA_W-1:0] regs [16];

    // Transaction captured at issue so WAIT holds the bus stable and idle cycles keep last values
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [3:0]        lat_dest;
    logic              lat_en;

    op_t               op;
    logic [3:0]        dest, arg1, arg2;
    logic [DATA_W-1:0] cval, rd, ra, rb, alu_res, ea;
    logic              is_mem, taken;
    logic              wr_en;
    logic [3:0]        wr_idx;
    logic [DATA_W-1:0] wr_dat;

    assign op     = op_t'(inst_data[15:12]);
    assign dest   = inst_data[11:8];
    assign arg1   = inst_data[7:4];
    assign arg2   = inst_data[3:0];
    assign cval   = DATA_W'(inst_data[7:0]);
    assign rd     = regs[dest];
    assign ra     = regs[arg1];
    assign rb     = regs[arg2];
    assign ea     = ra + DATA_W'(arg2);
    assign is_mem = (op == OP_LOAD) || (op == OP_STORE);
    assign taken  = (rd == cval) ^ (op == OP_BNEQ);

    // Shifts by >= DATA_W naturally yield zero for logical shifts
    always_comb begin
        alu_res = '0;
        case (op)
            OP_SET:  alu_res = cval;
            OP_LT:   alu_res = {{(DATA_W-1){1'b0}}, (ra < rb)};
            OP_EQ:   alu_res = {{(DATA_W-1){1'b0}}, (ra == rb)};
            OP_ADD:  alu_res = ra + rb;
            OP_SUB:  alu_res = ra - rb;
            OP_SHL:  alu_res = ra << rb;
            OP_SHR:  alu_res = ra >> rb;
            OP_AND:  alu_res = ra & rb;
            OP_OR:   alu_res = ra | rb;
            OP_INV:  alu_res = ~ra;
            OP_XOR:  alu_res = ra ^ rb;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        wr_en     = 1'b0;
        wr_idx    = dest;
        wr_dat    = alu_res;
        lat_en    = 1'b0;
        case (state)
            S_RUN: begin
                if (inst_data == HALT_INST) begin
                    state_nxt = S_HALT;
                end else if (is_mem) begin
                    lat_en = 1'b1;
                    if (mem_ack) begin
                        pc_nxt = pc + PC_W'(1);
                        if (op == OP_LOAD) begin
                            wr_en  = 1'b1;
                            wr_dat = mem_rdata;
                        end
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end else if ((op == OP_BEQ) || (op == OP_BNEQ)) begin
                    pc_nxt = taken ? pc + PC_W'(2) : pc + PC_W'(1);
                end else begin
                    pc_nxt = pc + PC_W'(1);
                    wr_en  = (op != OP_NOP);
                end
            end
            S_WAIT: begin
                if (mem_ack) begin
                    pc_nxt    = pc + PC_W'(1);
                    state_nxt = S_RUN;
                    if (!lat_we) begin
                        wr_en  = 1'b1;
                        wr_idx = lat_dest;
                        wr_dat = mem_rdata;
                    end
                end
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_RUN;
        endcase
    end

    // Gating on rst keeps mem_req low while reset is asserted, whatever the ROM presents
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
        if (!rst && (state == S_RUN) && is_mem) begin
            mem_req   = 1'b1;
            mem_we    = (op == OP_STORE);
            mem_addr  = ADDR_W'(ea);
            mem_wdata = rd;
        end else if (state == S_WAIT) begin
            mem_req = 1'b1;
        end
    end

    assign inst_addr = pc;
    assign halted    = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_RUN;
            pc        <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_dest  <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (lat_en) begin
                lat_we    <= (op == OP_STORE);
                lat_addr  <= ADDR_W'(ea);
                lat_wdata <= rd;
                lat_dest  <= dest;
            end
            if (wr_en) regs[wr_idx] <= wr_dat;
        end
    end
endmodule

// File: tb/tb_param_cpu.sv
// Bench for param_cpu: ISA-level reference model feeds an expected-transaction queue; a bus
// monitor/responder pops and compares each data-memory transfer. A second small instance covers wrap.
module tb_param_cpu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst2 = 1'b1;
    always #5 clk = ~clk;

    // Main instance, default parameters
    logic [7:0]  inst_addr, mem_addr, mem_wdata, mem_rdata;
    logic [15:0] inst_data;
    logic        mem_req, mem_we, mem_ack, halted;
    logic [15:0] rom [256];
    logic [7:0]  mem [256];
    logic [7:0]  mem_m [256];
    assign inst_data = rom[inst_addr];
    assign mem_rdata = mem[mem_addr];

    param_cpu dut (
        .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_data(inst_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .halted(halted)
    );

    // Wide-data, narrow-PC instance
    logic [3:0]  inst_addr2;
    logic [15:0] inst_data2, mem_wdata2, mem_rdata2;
    logic [11:0] mem_addr2;
    logic        mem_req2, mem_we2, mem_ack2, halted2;
    logic [15:0] rom2 [16];
    assign inst_data2 = rom2[inst_addr2];
    assign mem_ack2   = mem_req2;
    assign mem_rdata2 = '0;

    param_cpu #(.DATA_W(16), .ADDR_W(12), .PC_W(4)) dut2 (
        .clk(clk), .rst(rst2), .inst_addr(inst_addr2), .inst_data(inst_data2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ack(mem_ack2), .halted(halted2)
    );

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         pc;
    } txn_t;

    txn_t exp_q [$];
    int   wait_q [$];
    bit   rand_waits = 1'b0;
    int   exp_halt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Architectural model: executes the ROM instruction by instruction from reset state
    task automatic model_run(output int hpc);
        int r [16];
        int pc, op, d, a, b, c, addr;
        logic [15:0] ins;
        txn_t t;
        foreach (r[i]) r[i] = 0;
        pc  = 0;
        hpc = -1;
        for (int step = 0; step < 4000; step++) begin
            ins = rom[pc];
            if (ins == 16'h0FFF) begin
                hpc = pc;
                return;
            end
            op = int'(ins[15:12]); d = int'(ins[11:8]);
            a  = int'(ins[7:4]);   b = int'(ins[3:0]);  c = int'(ins[7:0]);
            addr = (r[a] + b) % 256;
            case (op)
                1: begin
                    t.we = 1'b0; t.addr = 8'(addr); t.wdata = 8'h00; t.pc = pc;
                    exp_q.push_back(t);
                    r[d] = int'(mem_m[addr]);
                end
                2: begin
                    t.we = 1'b1; t.addr = 8'(addr); t.wdata = 8'(r[d]); t.pc = pc;
                    exp_q.push_back(t);
                    mem_m[addr] = 8'(r[d]);
                end
                3:  r[d] = c;
                4:  r[d] = (r[a] < r[b]) ? 1 : 0;
                5:  r[d] = (r[a] == r[b]) ? 1 : 0;
                8:  r[d] = (r[a] + r[b]) % 256;
                9:  r[d] = (r[a] - r[b] + 256) % 256;
                10: r[d] = (r[b] >= 8) ? 0 : (r[a] << r[b]) % 256;
                11: r[d] = (r[b] >= 8) ? 0 : (r[a] >> r[b]);
                12: r[d] = r[a] & r[b];
                13: r[d] = r[a] | r[b];
                14: r[d] = 255 - r[a];
                15: r[d] = r[a] ^ r[b];
                default: ;
            endcase
            if ((op == 6 && r[d] == c) || (op == 7 && r[d] != c)) pc = (pc + 2) % 256;
            else                                                  pc = (pc + 1) % 256;
        end
    endtask

    function automatic logic [15:0] rand_inst();
        logic [3:0] op, d, a, b;
        logic [7:0] c;
        int sel;
        sel = int'($urandom_range(0, 9));
        d = 4'($urandom); a = 4'($urandom); b = 4'($urandom);
        case (sel)
            0, 1:    op = 4'h3;
            2:       op = 4'h1;
            3, 4:    op = 4'h2;
            default: op = 4'($urandom_range(4, 15));
        endcase
        if (op == 4'h3) begin
            c = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 9));
            return {op, d, c};
        end
        if (op == 4'h6 || op == 4'h7) begin
            c = 8'($urandom_range(0, 3));
            return {op, d, c};
        end
        return {op, d, a, b};
    endfunction

    // Bus monitor and memory responder: picks a wait count per transfer, checks every request cycle
    initial begin
        txn_t e;
        int   wleft;
        bit   in_txn;
        mem_ack = 1'b0;
        in_txn  = 1'b0;
        wleft   = 0;
        forever begin
            @(negedge clk);
            if (rst || !mem_req) begin
                mem_ack = 1'b0;
                in_txn  = 1'b0;
            end else begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    if (wait_q.size() > 0) wleft = wait_q.pop_front();
                    else if (rand_waits)   wleft = int'($urandom_range(0, 3));
                    else                   wleft = 0;
                end
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_txn: mem_req=1 at pc %0d, no transfer expected", inst_addr);
                end else begin
                    e = exp_q[0];
                    chk("txn_we", 32'(mem_we), 32'(e.we));
                    chk("txn_addr", 32'(mem_addr), 32'(e.addr));
                    chk("txn_pc", 32'(inst_addr), 32'(e.pc));
                    if (e.we) chk("txn_wdata", 32'(mem_wdata), 32'(e.wdata));
                end
                if (wleft == 0) begin
                    mem_ack = 1'b1;
                    in_txn  = 1'b0;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else begin
                    mem_ack = 1'b0;
                    wleft--;
                end
            end
        end
    end

    task automatic start_prog();
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 256; i++) mem_m[i] = mem[i];
        model_run(exp_halt);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic finish_prog(input int budget);
        for (int i = 0; i < budget && !halted; i++) begin
            @(negedge clk);
            #1;
        end
        chk("halt_reached", 32'(halted), 32'd1);
        chk("halt_pc", 32'(inst_addr), 32'(exp_halt));
        chk("txn_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("halt_hold_pc", 32'(inst_addr), 32'(exp_halt));
        chk("halt_no_req", 32'(mem_req), 32'd0);
    endtask

    task automatic fill_rom_halt();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0FFF;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_rom_halt();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) rom2[i] = 16'h0000;
        rom2[0] = 16'h31FF;   // SET R1,FF
        rom2[1] = 16'h3208;   // SET R2,08
        rom2[2] = 16'hA312;   // SHL R3,R1,R2
        rom2[3] = 16'h2330;   // STORE R3 -> [R3+0]
        rom2[4] = 16'h2100;   // STORE R1 -> [R0+0]
        repeat (2) @(negedge clk);

        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_pc", 32'(inst_addr), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Wide instance: zero-extended SET, truncated address, PC wrap and wrapped skip
        #1 rst2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("d2_req", 32'(mem_req2), 32'd1);
        chk("d2_we", 32'(mem_we2), 32'd1);
        chk("d2_addr", 32'(mem_addr2), 32'h0F00);
        chk("d2_wdata", 32'(mem_wdata2), 32'hFF00);
        @(posedge clk);
        #1;
        chk("d2_set_zext", 32'(mem_wdata2), 32'h00FF);
        chk("d2_addr0", 32'(mem_addr2), 32'h0000);
        for (int i = 0; i < 20 && inst_addr2 != 4'd15; i++) begin
            @(posedge clk);
            #1;
        end
        chk("d2_reach15", 32'(inst_addr2), 32'd15);
        @(posedge clk);
        #1;
        chk("d2_wrap0", 32'(inst_addr2), 32'd0);
        rom2[15] = 16'h6000;  // BEQ R0,00 (taken)
        for (int i = 0; i < 20 && inst_addr2 != 4'd15; i++) begin
            @(posedge clk);
            #1;
        end
        chk("d2_reach15b", 32'(inst_addr2), 32'd15);
        @(posedge clk);
        #1;
        chk("d2_skip_wrap1", 32'(inst_addr2), 32'd1);
        chk("d2_not_halted", 32'(halted2), 32'd0);
        rst2 = 1'b1;

        // Directed program: arithmetic, waited store, zero-wait load, shift overflow, branches
        fill_rom_halt();
        rom[0]  = 16'h3105;   // SET R1,05
        rom[1]  = 16'h3203;   // SET R2,03
        rom[2]  = 16'h8312;   // ADD R3,R1,R2
        rom[3]  = 16'h9421;   // SUB R4,R2,R1
        rom[4]  = 16'h2312;   // STORE R3 -> [R1+2]
        rom[5]  = 16'h1501;   // LOAD R5 <- [R0+1]
        rom[6]  = 16'h3709;   // SET R7,09
        rom[7]  = 16'hA617;   // SHL R6,R1,R7
        rom[8]  = 16'h2600;   // STORE R6 -> [R0+0]
        rom[9]  = 16'h0000;   // NOP
        rom[10] = 16'h65A5;   // BEQ R5,A5
        rom[11] = 16'h2000;   // skipped
        rom[12] = 16'h75A5;   // BNEQ R5,A5
        rom[13] = 16'h2400;   // STORE R4 -> [R0+0]
        mem[1] = 8'hA5;
        mem[7] = 8'h00;
        rand_waits = 1'b0;
        wait_q.delete();
        wait_q.push_back(3);
        start_prog();
        repeat (4) @(posedge clk);
        #1;
        chk("dir_pc4", 32'(inst_addr), 32'd4);
        finish_prog(200);
        chk("dir_mem7", 32'(mem[7]), 32'h08);
        chk("dir_mem0", 32'(mem[0]), 32'hFE);
        chk("dir_halt_pc", 32'(inst_addr), 32'd14);

        // Random programs with random wait states
        rand_waits = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rst = 1'b1;
            @(negedge clk);
            fill_rom_halt();
            for (int i = 0; i < 40; i++) rom[i] = rand_inst();
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            start_prog();
            finish_prog(3000);
        end

        // Reset during a LOAD wait: request drops at once, destination never written
        rand_waits = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        fill_rom_halt();
        rom[0] = 16'h1500;    // LOAD R5 <- [R0+0]
        mem[0] = 8'h5A;
        wait_q.delete();
        wait_q.push_back(20);
        start_prog();
        repeat (3) @(posedge clk);
        #2;
        chk("wait_req", 32'(mem_req), 32'd1);
        chk("wait_pc", 32'(inst_addr), 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_drop_req", 32'(mem_req), 32'd0);
        exp_q.delete();
        wait_q.delete();
        rom[0] = 16'h2500;    // STORE R5 -> [R0+0]
        rom[1] = 16'h0FFF;
        start_prog();
        finish_prog(100);
        chk("rst_r5_zero", 32'(mem[0]), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
